// File: rtl/puck_engine.sv
// puck_engine: puck stepping, wall/paddle bounces, scoring and game FSM for the 8x8 air-hockey matrix.
// Optional feature macro PUCK_SPEEDUP_EN: every 4th consecutive paddle hit halves the step period.
module puck_engine #(
  parameter int unsigned TICK_DIV    = 25_000_000,
  parameter int unsigned POINT_TICKS = 2,
  parameter int unsigned MAX_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] leftpos,
  input  logic [7:0] rightpos,
  input  logic       serve,
  output logic [7:0] puck_row,
  output logic [7:0] puck_col,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       game_over
);

  localparam logic [1:0] S_SERVE = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_POINT = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned PT_W  = (POINT_TICKS > 1) ? $clog2(POINT_TICKS) : 1;
  localparam logic [3:0]  MAX_S = 4'(MAX_SCORE);

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= MAX_S) ? s : s + 4'd1;
  endfunction

  logic [1:0]       state;
  logic [2:0]       row_q, col_q;
  logic             dx_right, dy_up;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_m1;
  logic [PT_W-1:0]  pcnt;
  logic             tick;

  logic [2:0] nrow, ncol;
  logic       ndx, ndy;
  logic       miss_r, miss_l;
  logic       left_scored;

`ifdef PUCK_SPEEDUP_EN
  logic [1:0] hits;
  logic [1:0] shift;
  logic       hit;

  assign period_m1 = CNT_W'((TICK_DIV >> shift) - 1);
  assign hit = (dx_right && col_q == 3'd6 && rightpos[row_q]) ||
               (!dx_right && col_q == 3'd1 && leftpos[row_q]);

  // Hit streak only ever grows within a rally; a point ends the rally and restores the base period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hits  <= 2'd0;
      shift <= 2'd0;
    end else if (state == S_PLAY && tick) begin
      if (miss_r || miss_l) begin
        hits  <= 2'd0;
        shift <= 2'd0;
      end else if (hit) begin
        hits <= hits + 2'd1;
        if (hits == 2'd3 && shift != 2'd2)
          shift <= shift + 2'd1;
      end
    end
  end
`else
  assign period_m1 = CNT_W'(TICK_DIV - 1);
`endif

  assign tick        = (cnt >= period_m1);
  assign left_scored = (col_q == 3'd7);
  assign puck_row    = 8'b1 << row_q;
  assign puck_col    = 8'b1 << col_q;

  // Next position from the pre-step position; paddle lookup uses the pre-step row.
  always_comb begin
    nrow   = row_q;
    ndy    = dy_up;
    ncol   = col_q;
    ndx    = dx_right;
    miss_r = 1'b0;
    miss_l = 1'b0;
    if (dy_up) begin
      if (row_q == 3'd7) begin
        ndy  = 1'b0;
        nrow = 3'd6;
      end else begin
        nrow = row_q + 3'd1;
      end
    end else begin
      if (row_q == 3'd0) begin
        ndy  = 1'b1;
        nrow = 3'd1;
      end else begin
        nrow = row_q - 3'd1;
      end
    end
    if (dx_right) begin
      if (col_q == 3'd6) begin
        if (rightpos[row_q]) begin
          ndx  = 1'b0;
          ncol = 3'd5;
        end else begin
          ncol   = 3'd7;
          miss_r = 1'b1;
        end
      end else begin
        ncol = col_q + 3'd1;
      end
    end else begin
      if (col_q == 3'd1) begin
        if (leftpos[row_q]) begin
          ndx  = 1'b1;
          ncol = 3'd2;
        end else begin
          ncol   = 3'd0;
          miss_l = 1'b1;
        end
      end else begin
        ncol = col_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_SERVE;
      row_q       <= 3'd4;
      col_q       <= 3'd3;
      dx_right    <= 1'b1;
      dy_up       <= 1'b1;
      left_score  <= 4'd0;
      right_score <= 4'd0;
      game_over   <= 1'b0;
      cnt         <= '0;
      pcnt        <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      case (state)
        S_SERVE: begin
          if (serve) begin
            state <= S_PLAY;
            cnt   <= '0;
          end
        end
        S_PLAY: begin
          if (tick) begin
            row_q    <= nrow;
            col_q    <= ncol;
            dx_right <= ndx;
            dy_up    <= ndy;
            if (miss_r) left_score <= sat_inc(left_score);
            if (miss_l) right_score <= sat_inc(right_score);
            if (miss_r || miss_l) begin
              state <= S_POINT;
              pcnt  <= '0;
            end
          end
        end
        S_POINT: begin
          if (tick) begin
            if (pcnt == PT_W'(POINT_TICKS - 1)) begin
              if ((left_scored ? left_score : right_score) == MAX_S) begin
                state     <= S_OVER;
                game_over <= 1'b1;
              end else begin
                state    <= S_SERVE;
                row_q    <= 3'd4;
                col_q    <= 3'd3;
                dx_right <= left_scored;
              end
            end else begin
              pcnt <= pcnt + PT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puck_engine.sv
// tb_puck_engine: randomized and directed stimulus for puck_engine, scoreboarded against
// a position/velocity reference model (honours PUCK_SPEEDUP_EN when defined).
module tb_puck_engine;
  localparam int TD = 4;
  localparam int PT = 2;
  localparam int MS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serve = 1'b0;
  logic [7:0] leftpos = 8'h00;
  logic [7:0] rightpos = 8'h00;
  logic [7:0] puck_row, puck_col;
  logic [3:0] left_score, right_score;
  logic       game_over;

  always #5 clk = ~clk;

  puck_engine #(.TICK_DIV(TD), .POINT_TICKS(PT), .MAX_SCORE(MS)) dut (
    .clk(clk), .reset(reset), .leftpos(leftpos), .rightpos(rightpos), .serve(serve),
    .puck_row(puck_row), .puck_col(puck_col), .left_score(left_score),
    .right_score(right_score), .game_over(game_over)
  );

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic [3:0] ls;
    logic [3:0] rs;
    logic       go;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Reference model: integer position, velocity +1/-1, phase 0=serve 1=play 2=point 3=over.
  int m_state, m_row, m_col, m_dx, m_dy, m_ls, m_rs, m_since, m_pt, m_hits, m_period;
  bit m_go, m_left_scored;

  task automatic paddle_hit();
    m_hits++;
`ifdef PUCK_SPEEDUP_EN
    if (m_hits % 4 == 0 && m_period / 2 >= TD / 4) m_period = m_period / 2;
`endif
  endtask

  task automatic goal(input bit left_scores);
    m_left_scored = left_scores;
    if (left_scores) m_ls = (m_ls < MS) ? m_ls + 1 : m_ls;
    else             m_rs = (m_rs < MS) ? m_rs + 1 : m_rs;
    m_state  = 2;
    m_pt     = 0;
    m_hits   = 0;
    m_period = TD;
  endtask

  task automatic model_edge(input bit rst_n, input bit sv, input logic [7:0] lp, input logic [7:0] rp);
    bit tk;
    int r, c, orow;
    if (!rst_n) begin
      m_state = 0; m_row = 4; m_col = 3; m_dx = 1; m_dy = 1; m_ls = 0; m_rs = 0;
      m_go = 0; m_since = 0; m_pt = 0; m_hits = 0; m_period = TD; m_left_scored = 0;
      return;
    end
    tk = (m_since + 1 >= m_period);
    m_since = tk ? 0 : m_since + 1;
    case (m_state)
      0: if (sv) begin m_state = 1; m_since = 0; end
      1: if (tk) begin
        orow = m_row;
        r = m_row + m_dy;
        if (r > 7) begin r = 6; m_dy = -1; end
        else if (r < 0) begin r = 1; m_dy = 1; end
        c = m_col + m_dx;
        if (c == 7) begin
          if (rp[orow]) begin c = 5; m_dx = -1; paddle_hit(); end
          else goal(1'b1);
        end else if (c == 0) begin
          if (lp[orow]) begin c = 2; m_dx = 1; paddle_hit(); end
          else goal(1'b0);
        end
        m_row = r;
        m_col = c;
      end
      2: if (tk) begin
        m_pt++;
        if (m_pt == PT) begin
          if ((m_left_scored ? m_ls : m_rs) == MS) begin
            m_state = 3; m_go = 1;
          end else begin
            m_state = 0; m_row = 4; m_col = 3; m_dx = m_left_scored ? 1 : -1;
          end
        end
      end
      default: ;
    endcase
  endtask

  // One clock: drive at negedge, push the expectation for the coming edge, return just after it.
  task automatic cyc(input bit rst_n, input bit sv, input logic [7:0] lp, input logic [7:0] rp);
    exp_t e;
    @(negedge clk);
    reset = rst_n; serve = sv; leftpos = lp; rightpos = rp;
    model_edge(rst_n, sv, lp, rp);
    e.row = 8'b1 << m_row;
    e.col = 8'b1 << m_col;
    e.ls  = 4'(m_ls);
    e.rs  = 4'(m_rs);
    e.go  = m_go;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_pos(input string name, input int r, input int c);
    logic [7:0] er, ec;
    er = 8'b1 << r;
    ec = 8'b1 << c;
    check(name, {16'h0, puck_row, puck_col}, {16'h0, er, ec});
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      check("pos", {16'h0, puck_row, puck_col}, {16'h0, me.row, me.col});
      check("score", {23'h0, left_score, right_score, game_over}, {23'h0, me.ls, me.rs, me.go});
    end
  end

  initial begin
    int guard;
    // Serve and first steps
    repeat (2) cyc(0, 0, 8'h00, 8'h00);
    check("reset_scores", {23'h0, left_score, right_score, game_over}, 32'h0);
    chk_pos("reset_pos", 4, 3);
    cyc(1, 1, 8'h00, 8'h00);
    repeat (3) cyc(1, 0, 8'h00, 8'h00);
    chk_pos("t1_hold", 4, 3);
    cyc(1, 0, 8'h00, 8'h00);
    chk_pos("t1_step1", 5, 4);
    repeat (4) cyc(1, 0, 8'h00, 8'h00);
    chk_pos("t1_step2", 6, 5);
    repeat (4) cyc(1, 0, 8'h00, 8'h00);
    chk_pos("t1_step3", 7, 6);
    // Corner hit plus top-wall bounce
    repeat (4) cyc(1, 0, 8'h00, 8'b11100000);
    chk_pos("t2_corner", 6, 5);
    repeat (4) cyc(1, 0, 8'h00, 8'b11100000);
    chk_pos("t2_dir", 5, 4);

    // Right paddle misses; left scores
    cyc(0, 0, 8'h00, 8'h00);
    cyc(1, 1, 8'h00, 8'b00000111);
    repeat (16) cyc(1, 0, 8'h00, 8'b00000111);
    chk_pos("t3_goal", 6, 7);
    check("t3_lscore", {28'h0, left_score}, 32'd1);
    repeat (4) cyc(1, 0, 8'h00, 8'b00000111);
    chk_pos("t3_held", 6, 7);
    repeat (4) cyc(1, 0, 8'h00, 8'b00000111);
    chk_pos("t3_reserve", 4, 3);

    // Left player misses twice -> game over, then frozen
    repeat (5) cyc(1, 1, 8'b11100000, 8'hFF);
    chk_pos("t4_dx_right", 3, 4);
    guard = 0;
    while (m_state != 3 && guard < 2000) begin
      cyc(1, 1, 8'b11100000, 8'hFF);
      guard++;
    end
    check("t4_over", {23'h0, left_score, right_score, game_over}, {23'h0, 4'd1, 4'd2, 1'b1});
    chk_pos("t4_over_pos", 3, 0);
    repeat (80) cyc(1, 1, 8'($urandom), 8'($urandom));
    chk_pos("t4_frozen_pos", 3, 0);
    check("t4_frozen_go", {31'h0, game_over}, 32'd1);

    // Reset in mid-PLAY with a nonzero score
    cyc(0, 0, 8'h00, 8'h00);
    guard = 0;
    while (!(m_state == 1 && m_rs == 1) && guard < 2000) begin
      cyc(1, 1, 8'h00, 8'hFF);
      guard++;
    end
    repeat (6) cyc(1, 0, 8'h00, 8'hFF);
    cyc(0, 0, 8'h00, 8'hFF);
    chk_pos("t5_reset_pos", 4, 3);
    check("t5_reset_scores", {23'h0, left_score, right_score, game_over}, 32'h0);
    repeat (8) cyc(1, 0, 8'h00, 8'hFF);
    chk_pos("t5_serve_held", 4, 3);

`ifdef PUCK_SPEEDUP_EN
    // Long rally with both paddles covering every row
    cyc(0, 0, 8'h00, 8'h00);
    cyc(1, 1, 8'hFF, 8'hFF);
    repeat (300) cyc(1, 0, 8'hFF, 8'hFF);
    repeat (200) cyc(1, 0, 8'h00, 8'hFF);
`endif

    // Randomized play, masks changing every cycle
    cyc(0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      bit rn;
      rn = ($urandom_range(0, 999) != 0) && !(m_state == 3 && $urandom_range(0, 39) == 0);
      cyc(rn, ($urandom_range(0, 7) == 0), 8'($urandom), 8'($urandom));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
